// File: rtl/xc_malu_issue.sv
// Issue/hold stage between the decode pipe and the multi-cycle MALU: latches one op, waits for the result, holds it for the consumer.
// Optional watchdog on a stalled MALU: define XC_MALU_ISSUE_WDOG_EN (limit set by TIMEOUT).
module xc_malu_issue #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_rs3,
    input  logic [13:0] in_uop,
    input  logic [4:0]  in_pw,
    input  logic        in_hi,
    input  logic        kill,
    output logic        malu_valid,
    output logic        malu_flush,
    output logic [31:0] malu_rs1,
    output logic [31:0] malu_rs2,
    output logic [31:0] malu_rs3,
    output logic [13:0] malu_uop,
    output logic [4:0]  malu_pw,
    input  logic [63:0] malu_result,
    input  logic        malu_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rd,
    output logic [31:0] out_rd2,
    output logic        out_err
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, CLR} state_t;

    state_t      state;
    logic [31:0] rs1_q, rs2_q, rs3_q, rd_q, rd2_q;
    logic [13:0] uop_q;
    logic [4:0]  pw_q;
    logic        hi_q, err_q, bypass_q;
    logic        uop_onehot;
`ifdef XC_MALU_ISSUE_WDOG_EN
    logic [15:0] wdog_cnt;
`endif

    assign uop_onehot = (in_uop != 14'd0) && ((in_uop & (in_uop - 14'd1)) == 14'd0);

    assign in_ready   = (state == IDLE) && !kill;
    // A malformed op spends its BUSY cycle with the MALU request suppressed
    assign malu_valid = (state == BUSY) && !bypass_q;
    assign malu_flush = (state == CLR);
    assign out_valid  = (state == HOLD);
    assign malu_rs1   = rs1_q;
    assign malu_rs2   = rs2_q;
    assign malu_rs3   = rs3_q;
    assign malu_uop   = uop_q;
    assign malu_pw    = pw_q;
    assign out_rd     = rd_q;
    assign out_rd2    = rd2_q;
    assign out_err    = err_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            rs3_q    <= 32'd0;
            uop_q    <= 14'd0;
            pw_q     <= 5'd0;
            hi_q     <= 1'b0;
            rd_q     <= 32'd0;
            rd2_q    <= 32'd0;
            err_q    <= 1'b0;
            bypass_q <= 1'b0;
`ifdef XC_MALU_ISSUE_WDOG_EN
            wdog_cnt <= 16'd0;
`endif
        end else if (kill && state != CLR) begin
            state <= CLR;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rs1_q    <= in_rs1;
                        rs2_q    <= in_rs2;
                        rs3_q    <= in_rs3;
                        uop_q    <= in_uop;
                        pw_q     <= in_pw;
                        hi_q     <= in_hi;
                        bypass_q <= !uop_onehot;
                        err_q    <= 1'b0;
`ifdef XC_MALU_ISSUE_WDOG_EN
                        wdog_cnt <= 16'd0;
`endif
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (bypass_q) begin
                        rd_q  <= 32'd0;
                        rd2_q <= 32'd0;
                        err_q <= 1'b1;
                        state <= HOLD;
                    end else if (malu_ready) begin
                        rd_q  <= hi_q ? malu_result[63:32] : malu_result[31:0];
                        rd2_q <= malu_result[63:32];
                        err_q <= 1'b0;
                        state <= HOLD;
                    end
`ifdef XC_MALU_ISSUE_WDOG_EN
                    // Counter value equals the number of BUSY cycles already spent
                    else if (wdog_cnt == 16'(TIMEOUT - 1)) begin
                        rd_q  <= 32'd0;
                        rd2_q <= 32'd0;
                        err_q <= 1'b1;
                        state <= HOLD;
                    end else begin
                        wdog_cnt <= wdog_cnt + 16'd1;
                    end
`endif
                end
                HOLD: begin
                    if (out_ready) state <= CLR;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xc_malu_issue.sv
// Randomized bench for xc_malu_issue: a MALU responder model plus a transaction scoreboard checked every cycle.
module tb_xc_malu_issue;

    logic        clock, resetn;
    logic        in_valid, in_ready, in_hi, kill;
    logic [31:0] in_rs1, in_rs2, in_rs3;
    logic [13:0] in_uop;
    logic [4:0]  in_pw;
    logic        malu_valid, malu_flush, malu_ready;
    logic [31:0] malu_rs1, malu_rs2, malu_rs3;
    logic [13:0] malu_uop;
    logic [4:0]  malu_pw;
    logic [63:0] malu_result;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rd, out_rd2;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] rd2;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int          malu_lat = 0;
    int          busy_cnt = 0;
    logic        cur_bypass = 1'b0;
    logic [31:0] cur_a, cur_b, cur_c;
    logic [13:0] cur_u;

    xc_malu_issue dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .in_uop(in_uop), .in_pw(in_pw), .in_hi(in_hi),
        .kill(kill),
        .malu_valid(malu_valid), .malu_flush(malu_flush),
        .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
        .malu_uop(malu_uop), .malu_pw(malu_pw),
        .malu_result(malu_result), .malu_ready(malu_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_rd2(out_rd2), .out_err(out_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference arithmetic used both by the MALU responder and the expectation
    function automatic logic [63:0] calc(input logic [13:0] u, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        logic signed [63:0] sa, sb, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        if (u == 14'h0020) return {32'd0, a} * {32'd0, b};
        if (u == 14'h0010) return sa * sb;
        if (u == 14'h0040) return sa * ub;
        if (u == 14'h0002) return (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
        return {a ^ c, a + b};
    endfunction

    function automatic exp_t expect_of(input logic [13:0] u, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic h);
        exp_t        e;
        logic [63:0] r;
        if ($countones(u) != 1) begin
            e.rd = 32'd0; e.rd2 = 32'd0; e.err = 1'b1;
        end else begin
            r = calc(u, a, b, c);
            e.rd = h ? r[63:32] : r[31:0]; e.rd2 = r[63:32]; e.err = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clock) busy_cnt <= malu_valid ? busy_cnt + 1 : 0;
    assign malu_ready  = malu_valid && (busy_cnt >= malu_lat);
    assign malu_result = calc(malu_uop, malu_rs1, malu_rs2, malu_rs3);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Per-cycle scoreboard and protocol checks
    always @(negedge clock) begin
        if (resetn) begin
            if (out_valid) begin
                if (expq.size() == 0) fail_now("spurious_out_valid");
                else begin
                    chk("out_rd", out_rd, expq[0].rd);
                    chk("out_rd2", out_rd2, expq[0].rd2);
                    chk("out_err", out_err, expq[0].err);
                    if (out_ready) void'(expq.pop_front());
                end
            end
            chk("in_ready_excl", in_ready && (malu_valid || out_valid || malu_flush), 1'b0);
            chk("bypass_no_malu_valid", malu_valid && cur_bypass, 1'b0);
            if (malu_valid) begin
                chk("malu_rs1", malu_rs1, cur_a);
                chk("malu_rs2", malu_rs2, cur_b);
                chk("malu_rs3", malu_rs3, cur_c);
                chk("malu_uop", malu_uop, cur_u);
            end
        end
    end

    task automatic send(input logic [13:0] u, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic h);
        int k;
        @(posedge clock); #1;
        in_valid = 1'b1; in_uop = u; in_rs1 = a; in_rs2 = b; in_rs3 = c; in_hi = h;
        in_pw = 5'(1 << $urandom_range(0, 4));
        k = 0;
        @(negedge clock);
        while (!in_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!in_ready) fail_now("accept_timeout");
        expq.push_back(expect_of(u, a, b, c, h));
        cur_bypass = ($countones(u) != 1);
        cur_a = a; cur_b = b; cur_c = c; cur_u = u;
        @(posedge clock); #1;
        in_valid = 1'b0; in_rs1 = $urandom; in_rs2 = $urandom; in_rs3 = $urandom; in_hi = $urandom_range(0, 1);
    endtask

    task automatic wait_out(output int n, output exp_t got);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out_valid && n < 2000);
        if (!out_valid) fail_now("out_valid_timeout");
        got.rd = out_rd; got.rd2 = out_rd2; got.err = out_err;
    endtask

    task automatic release_out(input int stall, input logic kill_clr);
        repeat (stall) @(posedge clock);
        @(posedge clock); #1 out_ready = 1'b1;
        @(posedge clock); #1 out_ready = 1'b0;
        if (kill_clr) kill = 1'b1;
        @(negedge clock);
        chk("clr_flush", malu_flush, 1'b1);
        chk("clr_out_valid", out_valid, 1'b0);
        if (kill_clr) begin
            @(posedge clock); #1 kill = 1'b0;
        end
        @(negedge clock);
        chk("idle_flush", malu_flush, 1'b0);
        chk("idle_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   n;
        exp_t got;
        logic [13:0] u;
        int   i0, j0;

        resetn = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        in_rs1 = 32'd0; in_rs2 = 32'd0; in_rs3 = 32'd0; in_uop = 14'd0; in_pw = 5'd1; in_hi = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_malu_valid", malu_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flush", malu_flush, 1'b0);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_out_rd", out_rd, 32'd0);
        @(posedge clock); #1 resetn = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1'b1);

        // mulu high word
        malu_lat = 0;
        send(14'h0020, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1);
        wait_out(n, got);
        chk("mulu_latency", n, 2);
        chk("mulu_rd", got.rd, 32'hFFFFFFFE);
        chk("mulu_rd2", got.rd2, 32'hFFFFFFFE);
        chk("mulu_err", got.err, 1'b0);
        release_out(0, 1'b0);

        // divu with consumer stall
        malu_lat = 1;
        send(14'h0002, 32'd100, 32'd7, 32'd0, 1'b0);
        wait_out(n, got);
        chk("divu_latency", n, 3);
        chk("divu_rd", got.rd, 32'd14);
        chk("divu_rd2", got.rd2, 32'd2);
        release_out(5, 1'b0);

        // signed mul low word
        malu_lat = 3;
        send(14'h0010, 32'hFFFFFFFD, 32'd5, 32'd0, 1'b0);
        wait_out(n, got);
        chk("mul_latency", n, 5);
        chk("mul_rd", got.rd, 32'hFFFFFFF1);
        chk("mul_rd2", got.rd2, 32'hFFFFFFFF);
        release_out(1, 1'b1);

        // malformed uop bypasses the MALU
        send(14'h0030, 32'h12345678, 32'h9, 32'd0, 1'b0);
        wait_out(n, got);
        chk("bad_uop_latency", n, 2);
        chk("bad_uop_err", got.err, 1'b1);
        chk("bad_uop_rd", got.rd, 32'd0);
        release_out(0, 1'b0);

        // kill on the third BUSY cycle
        malu_lat = 1000000;
        send(14'h0010, 32'd3, 32'd4, 32'd0, 1'b0);
        @(posedge clock); @(posedge clock); #1 kill = 1'b1;
        @(posedge clock); #1 kill = 1'b0;
        expq.delete();
        @(negedge clock);
        chk("kill_flush", malu_flush, 1'b1);
        chk("kill_out_valid", out_valid, 1'b0);
        chk("kill_malu_valid", malu_valid, 1'b0);
        @(negedge clock);
        chk("kill_in_ready", in_ready, 1'b1);
        chk("kill_flush_single", malu_flush, 1'b0);

        // kill together with in_valid does not accept
        @(posedge clock); #1 in_valid = 1'b1; in_uop = 14'h0020; kill = 1'b1;
        @(negedge clock);
        chk("kill_blocks_ready", in_ready, 1'b0);
        @(posedge clock); #1 in_valid = 1'b0; kill = 1'b0;
        @(negedge clock);
        chk("kill_idle_flush", malu_flush, 1'b1);
        chk("kill_idle_no_busy", malu_valid, 1'b0);
        @(negedge clock);
        chk("kill_idle_back", in_ready, 1'b1);

        // stalled MALU
        malu_lat = 1000000;
        send(14'h0020, 32'd6, 32'd7, 32'd0, 1'b0);
`ifdef XC_MALU_ISSUE_WDOG_EN
        expq[0].rd = 32'd0; expq[0].rd2 = 32'd0; expq[0].err = 1'b1;
        wait_out(n, got);
        chk("wdog_latency", n, 65);
        chk("wdog_err", got.err, 1'b1);
        chk("wdog_rd", got.rd, 32'd0);
        release_out(0, 1'b0);
`else
        repeat (1000) @(negedge clock);
        chk("nowdog_busy", malu_valid, 1'b1);
        chk("nowdog_no_out", out_valid, 1'b0);
        @(posedge clock); #1 kill = 1'b1;
        @(posedge clock); #1 kill = 1'b0;
        expq.delete();
        @(negedge clock);
        chk("nowdog_kill_flush", malu_flush, 1'b1);
        @(negedge clock);
        chk("nowdog_in_ready", in_ready, 1'b1);
`endif

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0: u = 14'd0;
                1: begin
                    i0 = $urandom_range(0, 13);
                    j0 = (i0 + 1 + $urandom_range(0, 12)) % 14;
                    u = (14'd1 << i0) | (14'd1 << j0);
                end
                default: u = 14'd1 << $urandom_range(0, 13);
            endcase
            malu_lat = $urandom_range(0, 4);
            send(u, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
            wait_out(n, got);
            chk("rand_latency", n, ($countones(u) != 1) ? 2 : malu_lat + 2);
            release_out($urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        // asynchronous reset in BUSY
        malu_lat = 1000000;
        send(14'h0010, 32'd11, 32'd13, 32'd0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("arst_malu_valid", malu_valid, 1'b0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_flush", malu_flush, 1'b0);
        expq.delete();
        @(posedge clock); #1 resetn = 1'b1;
        @(negedge clock);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_no_flush", malu_flush, 1'b0);
        chk("arst_out_rd", out_rd, 32'd0);
        chk("arst_out_err", out_err, 1'b0);
        chk("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
